morse_player: RTL and testbench



---
 rtl/morse_pkg.sv | 27 ++
 rtl/morse_rom.sv | 68 ++++++
 rtl/morse_player.sv | 138 +++++++++++++
 tb/tb_morse_player.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse character player: FSM state encoding,
// character code range, symbol count limit and timing unit multiples.
package morse_pkg;

  localparam int unsigned CODE_W = 6;
  localparam int unsigned PAT_W  = 6;
  localparam int unsigned LEN_W  = 3;

  localparam int unsigned CODE_MIN = 1;
  localparam int unsigned CODE_MAX = 39;
  localparam int unsigned MAX_SYMS = 6;

  // Durations in Morse time units
  localparam int unsigned DOT_UNITS      = 1;
  localparam int unsigned DASH_UNITS     = 3;
  localparam int unsigned SYM_GAP_UNITS  = 1;
  localparam int unsigned CHAR_GAP_UNITS = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_CHARGAP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/morse_rom.sv
// Combinational Morse lookup.
//   char_code_i : 1-26 A-Z, 27-36 digits 0-9, 37 '.', 38 ',', 39 '?'
//   pattern_o   : symbols left-aligned, first symbol in the MSB, 1 = dash
//   len_o       : number of symbols (0 for invalid codes)
//   valid_o     : char_code_i is in the supported range
module morse_rom
  import morse_pkg::*;
(
  input  logic [CODE_W-1:0] char_code_i,
  output logic [PAT_W-1:0]  pattern_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              valid_o
);

  // Table entries are {length, pattern right-aligned}; aligned to the MSB below
  logic [LEN_W+PAT_W-1:0] ent;

  always_comb begin
    ent = '0;
    case (char_code_i)
      6'd1:  ent = {3'd2, 6'b000001};
      6'd2:  ent = {3'd4, 6'b001000};
      6'd3:  ent = {3'd4, 6'b001010};
      6'd4:  ent = {3'd3, 6'b000100};
      6'd5:  ent = {3'd1, 6'b000000};
      6'd6:  ent = {3'd4, 6'b000010};
      6'd7:  ent = {3'd3, 6'b000110};
      6'd8:  ent = {3'd4, 6'b000000};
      6'd9:  ent = {3'd2, 6'b000000};
      6'd10: ent = {3'd4, 6'b000111};
      6'd11: ent = {3'd3, 6'b000101};
      6'd12: ent = {3'd4, 6'b000100};
      6'd13: ent = {3'd2, 6'b000011};
      6'd14: ent = {3'd2, 6'b000010};
      6'd15: ent = {3'd3, 6'b000111};
      6'd16: ent = {3'd4, 6'b000110};
      6'd17: ent = {3'd4, 6'b001101};
      6'd18: ent = {3'd3, 6'b000010};
      6'd19: ent = {3'd3, 6'b000000};
      6'd20: ent = {3'd1, 6'b000001};
      6'd21: ent = {3'd3, 6'b000001};
      6'd22: ent = {3'd4, 6'b000001};
      6'd23: ent = {3'd3, 6'b000011};
      6'd24: ent = {3'd4, 6'b001001};
      6'd25: ent = {3'd4, 6'b001011};
      6'd26: ent = {3'd4, 6'b001100};
      6'd27: ent = {3'd5, 6'b011111};
      6'd28: ent = {3'd5, 6'b001111};
      6'd29: ent = {3'd5, 6'b000111};
      6'd30: ent = {3'd5, 6'b000011};
      6'd31: ent = {3'd5, 6'b000001};
      6'd32: ent = {3'd5, 6'b000000};
      6'd33: ent = {3'd5, 6'b010000};
      6'd34: ent = {3'd5, 6'b011000};
      6'd35: ent = {3'd5, 6'b011100};
      6'd36: ent = {3'd5, 6'b011110};
      6'd37: ent = {3'd6, 6'b010101};
      6'd38: ent = {3'd6, 6'b110011};
      6'd39: ent = {3'd6, 6'b001100};
      default: ent = '0;
    endcase
  end

  assign len_o     = ent[PAT_W +: LEN_W];
  assign pattern_o = ent[PAT_W-1:0] << (LEN_W'(MAX_SYMS) - ent[PAT_W +: LEN_W]);
  assign valid_o   = (char_code_i >= CODE_W'(CODE_MIN)) && (char_code_i <= CODE_W'(CODE_MAX));

endmodule

// File: rtl/morse_player.sv
// Plays one Morse character per accepted request on a single key output.
//   clk, rst   : clock, asynchronous active-high reset
//   char_code  : character select, sampled with start in IDLE only
//   start      : play request (level-sampled in IDLE)
//   key_out    : 1 = mark, 0 = space
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse at the end of each accepted request
//   err        : with done, flags an invalid code (nothing played)
module morse_player
  import morse_pkg::*;
#(
  parameter int unsigned TICKS_PER_UNIT = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] char_code,
  input  logic              start,
  output logic              key_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(3 * TICKS_PER_UNIT);

  // Last timer value of each timed state
  localparam logic [CNT_W-1:0] DOT_LAST     = CNT_W'(DOT_UNITS * TICKS_PER_UNIT - 1);
  localparam logic [CNT_W-1:0] DASH_LAST    = CNT_W'(DASH_UNITS * TICKS_PER_UNIT - 1);
  localparam logic [CNT_W-1:0] SPACE_LAST   = CNT_W'(SYM_GAP_UNITS * TICKS_PER_UNIT - 1);
  localparam logic [CNT_W-1:0] CHARGAP_LAST = CNT_W'(CHAR_GAP_UNITS * TICKS_PER_UNIT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic               key_q, busy_q, done_q, err_q;
  logic               err_d;

  logic [PAT_W-1:0]   rom_pat;
  logic [LEN_W-1:0]   rom_len;
  logic               rom_valid;
  logic               sym_dash_c;
  logic [CNT_W-1:0]   mark_last_c;

  morse_rom u_rom (
    .char_code_i (char_code),
    .pattern_o   (rom_pat),
    .len_o       (rom_len),
    .valid_o     (rom_valid)
  );

  // Current symbol: pattern is MSB-aligned, index 0 is the first symbol
  assign sym_dash_c  = pat_q[LEN_W'(PAT_W - 1) - idx_q];
  assign mark_last_c = sym_dash_c ? DASH_LAST : DOT_LAST;

  // Next-state, timer, index and output decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pat_d   = pat_q;
    err_d   = 1'b0;
    cnt_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (rom_valid) begin
            state_d = ST_MARK;
            pat_d   = rom_pat;
            len_d   = rom_len;
            idx_d   = '0;
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end
      ST_MARK: begin
        if (cnt_q == mark_last_c) begin
          if ((idx_q + LEN_W'(1)) < len_q) begin
            state_d = ST_SPACE;
            idx_d   = idx_q + LEN_W'(1);
          end else begin
            state_d = ST_CHARGAP;
          end
        end
      end
      ST_SPACE: begin
        if (cnt_q == SPACE_LAST) state_d = ST_MARK;
      end
      ST_CHARGAP: begin
        if (cnt_q == CHARGAP_LAST) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Timer restarts on every state entry and idles at zero
    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      key_q   <= (state_d == ST_MARK);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      err_q   <= err_d;
    end
  end

  assign key_out = key_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_morse_player.sv
// Randomized scoreboard bench for morse_player (TICKS_PER_UNIT = 4).
module tb_morse_player;

  localparam int unsigned T = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] char_code;
  logic       key_out, busy, done, err;

  int checks = 0;
  int errors = 0;
  int spurious = 0;

  bit    exp_err_q[$];
  string exp_wave_q[$];
  int    exp_busy_q[$];

  morse_player #(.TICKS_PER_UNIT(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .char_code (char_code),
    .start     (start),
    .key_out   (key_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference: International Morse code as dot/dash text
  function automatic string morse_of(int code);
    case (code)
      1: return ".-";     2: return "-...";   3: return "-.-.";   4: return "-..";
      5: return ".";      6: return "..-.";   7: return "--.";    8: return "....";
      9: return "..";     10: return ".---";  11: return "-.-";   12: return ".-..";
      13: return "--";    14: return "-.";    15: return "---";   16: return ".--.";
      17: return "--.-";  18: return ".-.";   19: return "...";   20: return "-";
      21: return "..-";   22: return "...-";  23: return ".--";   24: return "-..-";
      25: return "-.--";  26: return "--..";
      27: return "-----"; 28: return ".----"; 29: return "..---"; 30: return "...--";
      31: return "....-"; 32: return "....."; 33: return "-...."; 34: return "--...";
      35: return "---.."; 36: return "----.";
      37: return ".-.-.-"; 38: return "--..--"; 39: return "..--..";
      default: return "";
    endcase
  endfunction

  // Expected key runs while playing, e.g. "4H4L12H12L" for ".-"
  function automatic string wave_of(string m);
    string s = "";
    for (int i = 0; i < m.len(); i++) begin
      s = {s, $sformatf("%0dH", (m[i] == "-") ? 3 * T : T)};
      s = {s, $sformatf("%0dL", (i == m.len() - 1) ? 3 * T : T)};
    end
    return s;
  endfunction

  function automatic int busy_of(string m);
    int n = 1;
    for (int i = 0; i < m.len(); i++) begin
      n += (m[i] == "-") ? 3 * T : T;
      n += (i == m.len() - 1) ? 3 * T : T;
    end
    return n;
  endfunction

  task automatic push_expected(input int code);
    string m = morse_of(code);
    exp_err_q.push_back(m.len() == 0);
    exp_wave_q.push_back(wave_of(m));
    exp_busy_q.push_back(busy_of(m));
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got '%s' expected '%s' at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_int({tag, "_key"},  int'(key_out), 0);
    check_int({tag, "_busy"}, int'(busy), 0);
    check_int({tag, "_done"}, int'(done), 0);
    check_int({tag, "_err"},  int'(err), 0);
  endtask

  // Monitor: rebuilds key runs during each busy period and scores on done
  string run_s = "";
  int    run_len = 0;
  logic  run_val = 1'b0;
  int    busy_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      run_s = ""; run_len = 0; busy_cnt = 0;
    end else begin
      if (!busy && (key_out || done || err)) spurious++;
      if (err && !done) spurious++;
      if (busy) begin
        busy_cnt++;
        if (done) begin
          if (run_len > 0) run_s = {run_s, $sformatf("%0d%s", run_len, run_val ? "H" : "L")};
          if (exp_err_q.size() == 0) begin
            check_int("unexpected_done", 1, 0);
          end else begin
            check_int("err", int'(err), int'(exp_err_q.pop_front()));
            check_str("wave", run_s, exp_wave_q.pop_front());
            check_int("busy_len", busy_cnt, exp_busy_q.pop_front());
          end
          run_s = ""; run_len = 0; busy_cnt = 0;
        end else begin
          if (run_len > 0 && key_out !== run_val) begin
            run_s = {run_s, $sformatf("%0d%s", run_len, run_val ? "H" : "L")};
            run_len = 0;
          end
          run_val = key_out;
          run_len++;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_int("idle_timeout", 1, 0);
  endtask

  // One request: start for a single cycle, then scramble char_code mid-play
  task automatic play(input int code);
    wait_idle();
    char_code = 6'(code);
    start = 1'b1;
    @(posedge clk);
    push_expected(code);
    #1;
    check_int("accept", int'(busy), 1);
    start = 1'b0;
    char_code = 6'($urandom_range(0, 63));
  endtask

  initial begin
    int code;
    int n;
    rst = 1'b1;
    start = 1'b0;
    char_code = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed characters and invalid codes
    play(5);
    play(1);
    play(38);
    play(0);
    play(40);

    // Reset in the second mark of 'A'
    play(1);
    repeat (12) @(negedge clk);
    check_int("pre_rst_mark", int'(key_out), 1);
    #2;
    rst = 1'b1;
    void'(exp_err_q.pop_back());
    void'(exp_wave_q.pop_back());
    void'(exp_busy_q.pop_back());
    #1;
    check_quiet("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_int("no_restart", int'(busy), 0);
    play(20);

    // start held high, code changed mid-play, one idle cycle between
    wait_idle();
    char_code = 6'd1;
    start = 1'b1;
    @(posedge clk);
    push_expected(1);
    #1;
    check_int("hold_accept", int'(busy), 1);
    repeat (6) @(negedge clk);
    char_code = 6'd14;
    push_expected(14);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_int("hold_done_seen", int'(done), 1);
    @(negedge clk);
    check_int("gap_idle", int'(busy), 0);
    @(negedge clk);
    check_int("gap_reaccept", int'(busy), 1);
    start = 1'b0;

    // Random codes, mostly valid
    repeat (30) begin
      if ($urandom_range(0, 3) == 0) begin
        code = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(40, 63));
      end else begin
        code = int'($urandom_range(1, 39));
      end
      play(code);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    n = 0;
    while (exp_err_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_int("drain_pending", exp_err_q.size(), 0);
    repeat (3) @(negedge clk);
    check_int("spurious_outputs", spurious, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
